// File: rtl/mul_issue_pkg.sv
// Shared encodings for the EX-stage multiply initiator: FSM states, ex_op codes,
// and the product word select.
package mul_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MUL_W   = 2'b00,
        MULH_W  = 2'b01,
        MULH_WU = 2'b10,
        MUL_RSV = 2'b11
    } op_t;

    function automatic logic [31:0] sel_word(input logic [63:0] prod, input logic high);
        return high ? prod[63:32] : prod[31:0];
    endfunction

endpackage

// File: rtl/mul_reuse_buf.sv
// One-entry reuse buffer: remembers the last completed operands, signedness and
// 64-bit product, and flags a hit when EX presents the same multiply again.
module mul_reuse_buf
    import mul_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic [31:0] upd_src1,
    input  logic [31:0] upd_src2,
    input  logic        upd_signed,
    input  logic [63:0] upd_prod,
    input  logic [31:0] q_src1,
    input  logic [31:0] q_src2,
    input  logic        q_signed,
    output logic        hit,
    output logic [63:0] prod
);

    logic        vld;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sgn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= 1'b0;
            src1 <= '0;
            src2 <= '0;
            sgn  <= 1'b0;
            prod <= '0;
        end else if (upd) begin
            vld  <= 1'b1;
            src1 <= upd_src1;
            src2 <= upd_src2;
            sgn  <= upd_signed;
            prod <= upd_prod;
        end
    end

    assign hit = vld && (src1 == q_src1) && (src2 == q_src2) && (sgn == q_signed);

endmodule

// File: rtl/mul_issue.sv
// EX-stage initiator for the start/done multiplier handshake.
// Optional reuse buffer enabled by defining MUL_ISSUE_REUSE_EN.
module mul_issue
    import mul_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  ex_op,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    input  logic        flush,
    output logic        ex_stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_reg1,
    output logic [31:0] mul_reg2,
    input  logic        mul_done,
    input  logic [63:0] mul_result
);

    state_t state;
    state_t next;
    logic   sel_high;
    logic   hit;
    logic   accept;
    logic   capture;
    logic   op_high;
    logic   op_signed;

    assign accept    = ex_valid & ~flush;
    assign capture   = (state == WAIT) & mul_done & ~flush;
    assign op_high   = (ex_op == MULH_W) | (ex_op == MULH_WU);
    assign op_signed = (ex_op != MULH_WU);

`ifdef MUL_ISSUE_REUSE_EN
    logic [63:0] buf_prod;

    mul_reuse_buf u_reuse (
        .clk        (clk),
        .rst        (rst),
        .upd        (capture),
        .upd_src1   (mul_reg1),
        .upd_src2   (mul_reg2),
        .upd_signed (mul_signed),
        .upd_prod   (mul_result),
        .q_src1     (ex_src1),
        .q_src2     (ex_src2),
        .q_signed   (op_signed),
        .hit        (hit),
        .prod       (buf_prod)
    );
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next      = state;
        mul_start = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE:  if (accept) next = hit ? RESP : ISSUE;
            ISSUE: begin
                mul_start = 1'b1;
                next      = WAIT;
            end
            WAIT:  if (mul_done) next = RESP;
            RESP: begin
                res_valid = ~flush;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
        ex_stall = rst & ex_valid & ~flush & (state != RESP);
    end

    // Operands are latched once in IDLE; later EX changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_high   <= 1'b0;
            mul_signed <= 1'b0;
            mul_reg1   <= '0;
            mul_reg2   <= '0;
            res_data   <= '0;
        end else begin
            if (state == IDLE && accept) begin
                sel_high <= op_high;
                if (hit) begin
`ifdef MUL_ISSUE_REUSE_EN
                    res_data <= sel_word(buf_prod, op_high);
`endif
                end else begin
                    mul_reg1   <= ex_src1;
                    mul_reg2   <= ex_src2;
                    mul_signed <= op_signed;
                end
            end
            if (capture) res_data <= sel_word(mul_result, sel_high);
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue with a behavioural multiplier and result model.
// Reuse-hit expectations follow MUL_ISSUE_REUSE_EN when it is defined.
module tb_mul_issue;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic        flush;
    logic        ex_stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_reg1;
    logic [31:0] mul_reg2;
    logic        mul_done;
    logic [63:0] mul_result;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // reuse model state (last completed, non-flushed multiply)
    bit          rv = 0;
    logic [31:0] ra, rb;
    bit          rs;

    mul_issue dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_src1    (ex_src1),
        .ex_src2    (ex_src2),
        .flush      (flush),
        .ex_stall   (ex_stall),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .mul_reg1   (mul_reg1),
        .mul_reg2   (mul_reg2),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] m_prod(input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier: done exactly one cycle after start, product of latched operands.
    initial begin
        logic        pend;
        logic [31:0] pa, pb;
        logic        ps;
        mul_done   = 0;
        mul_result = 0;
        forever begin
            @(negedge clk);
            pend = mul_start;
            pa = mul_reg1;
            pb = mul_reg2;
            ps = mul_signed;
            @(posedge clk);
            #1;
            mul_done   = pend;
            mul_result = pend ? m_prod(pa, pb, ps) : {$urandom, $urandom};
        end
    end

    // Compare process: every delivered result must match the model queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_res_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data_model", res_data, e);
                end
            end
        end
    end

    task automatic do_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit);
        bit          sg = (op != 2'd2);
        bit          hi = (op == 2'd1) || (op == 2'd2);
        bit          hit = 0;
        int          lat;
        logic [63:0] p;
        p = m_prod(a, b, sg);
`ifdef MUL_ISSUE_REUSE_EN
        hit = rv && (ra == a) && (rb == b) && (rs == sg);
`endif
        lat = hit ? 1 : 3;
        exp_q.push_back(hi ? p[63:32] : p[31:0]);
        ex_valid = 1;
        ex_op    = op;
        ex_src1  = a;
        ex_src2  = b;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk("ex_stall", ex_stall, (c < lat) ? 1 : 0);
            chk("mul_start", mul_start, (!hit && c == 1) ? 1 : 0);
            chk("res_valid", res_valid, (c == lat) ? 1 : 0);
            if (!hit && c == 1) begin
                chk("mul_signed", mul_signed, sg);
                chk("mul_reg1", mul_reg1, a);
                chk("mul_reg2", mul_reg2, b);
            end
            if (c == lat) chk("res_data_lit", res_data, lit);
            @(posedge clk);
            #1;
            if (c == 1) begin
                ex_op   = ~op;
                ex_src1 = ~a;
                ex_src2 = a ^ 32'h5A5A_5A5A;
            end
            if (c == lat) ex_valid = 0;
        end
        if (!hit) begin
            rv = 1;
            ra = a;
            rb = b;
            rs = sg;
        end
    endtask

    initial begin
        rst      = 0;
        ex_valid = 1;
        ex_op    = 0;
        ex_src1  = 32'h1111_1111;
        ex_src2  = 32'h2222_2222;
        flush    = 0;
        repeat (2) @(negedge clk);
        chk("rst_ex_stall", ex_stall, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mul_signed", mul_signed, 0);
        chk("rst_mul_reg1", mul_reg1, 0);
        chk("rst_mul_reg2", mul_reg2, 0);
        chk("rst_res_data", res_data, 0);
        @(posedge clk);
        #1;
        rst      = 1;
        ex_valid = 0;

        do_mul(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        do_mul(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        do_mul(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        do_mul(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);

        // flush in WAIT coinciding with mul_done: no result, back to IDLE
        ex_valid = 1;
        ex_op    = 2'd0;
        ex_src1  = 32'h0000_1234;
        ex_src2  = 32'h0000_0010;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_seq_start", mul_start, 1);
        @(posedge clk);
        #1;
        flush = 1;
        @(negedge clk);
        chk("flush_done_seen", mul_done, 1);
        chk("flush_ex_stall", ex_stall, 0);
        chk("flush_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        flush    = 0;
        ex_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_flush_res_valid", res_valid, 0);
            chk("post_flush_mul_start", mul_start, 0);
            @(posedge clk);
            #1;
        end
        do_mul(2'd0, 32'd3, 32'd5, 32'h0000_000F);

        // asynchronous reset during ISSUE
        ex_valid = 1;
        ex_op    = 2'd0;
        ex_src1  = 32'd9;
        ex_src2  = 32'd9;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_seq_start", mul_start, 1);
        #2;
        rst = 0;
        #1;
        chk("arst_mul_start", mul_start, 0);
        chk("arst_ex_stall", ex_stall, 0);
        chk("arst_mul_reg1", mul_reg1, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_mul_signed", mul_signed, 0);
        ex_valid = 0;
        rv = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("post_rst_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        do_mul(2'd0, 32'd7, 32'd6, 32'h0000_002A);

        do_mul(2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        do_mul(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        do_mul(2'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        do_mul(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        do_mul(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        do_mul(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        repeat (2) @(negedge clk);
        chk("results_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
# mul_issue

Execute-stage initiator for the start/done multiplier handshake. It accepts a decoded LoongArch multiply (MUL.W, MULH.W, MULH.WU) from EX, launches one multiplier operation, stalls EX until the 64-bit product returns, and delivers the selected 32-bit word. It sits between the EX-stage operand mux and the multiplier; it owns stall generation and flush cleanup for multiplies.

## Interface
- Parameters: none. Widths are fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX holds a multiply instruction.
- `ex_op`  in  2  00 MUL.W (low word, signed), 01 MULH.W (high word, signed), 10 MULH.WU (high word, unsigned), 11 reserved (treated as MUL.W).
- `ex_src1`, `ex_src2`  in  32  operands.
- `flush`  in  1  pipeline flush; kills the in-flight multiply.
- `ex_stall`  out  1  holds EX while the multiply is unresolved.
- `res_valid`  out  1  one-cycle pulse; `res_data` is valid.
- `res_data`  out  32  selected result word.
- `mul_start`  out  1  one-cycle launch pulse to the multiplier.
- `mul_signed`  out  1  signed-operand select to the multiplier.
- `mul_reg1`, `mul_reg2`  out  32  latched operands.
- `mul_done`  in  1  multiplier completion pulse; fixed at 1 cycle after `mul_start`.
- `mul_result`  in  64  product, valid while `mul_done` is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On `ex_valid & ~flush`: latch operands into `mul_reg1`/`mul_reg2`, set `mul_signed = (ex_op != 10)`, latch the high/low select, go to ISSUE.
- ISSUE: `mul_start = 1` for exactly this cycle; go to WAIT.
- WAIT:
  - `mul_done` is accepted only in this state.
  - On `mul_done`: register `res_data = sel_high ? mul_result[63:32] : mul_result[31:0]`, go to RESP.
- RESP: `res_valid = 1` and `ex_stall = 0`; EX advances at the end of this cycle. Return to IDLE.
- `ex_stall = ex_valid & ~flush & (state != RESP)`. It is 0 while `rst` is low.
- Flush:
  - `flush` in any state forces IDLE on the next edge.
  - `res_valid` is suppressed in the flush cycle, including RESP.
  - A stale `mul_done` arriving in IDLE or ISSUE is ignored.
- Back-to-back multiplies: the new instruction is seen in IDLE the cycle after RESP. There is no overlap.
- `ex_op` and `ex_src*` changes after the IDLE latch are ignored.

## Timing
- Reset values:
  - state IDLE.
  - `mul_start`, `mul_signed`, `res_valid` are 0.
  - `mul_reg1`, `mul_reg2`, `res_data` are 0.
- Latency with cycle 0 = `ex_valid` in IDLE:
  - cycle 1: `mul_start`.
  - cycle 2: `mul_done` is captured.
  - cycle 3: `res_valid`.
  - `ex_stall` is high in cycles 0–2.
- Reset asserted mid-operation: all state clears immediately. Outputs take their reset values asynchronously.

## Configuration
- `MUL_ISSUE_REUSE_EN` defined:
  - A one-entry reuse buffer holds the last completed operands, signedness and full 64-bit product.
  - In IDLE, on a hit (valid entry with equal `ex_src1`, `ex_src2` and signedness), go directly to RESP with `res_data` selected from the stored product. No `mul_start` is issued.
  - Hit latency: `res_valid` in cycle 1, `ex_stall` high only in cycle 0.
  - The entry is updated on each WAIT capture that is not flushed. It is invalidated only by reset.
- Not defined: every multiply takes the full ISSUE/WAIT path. No buffer storage is generated.

## Structure
- Shared package `mul_issue_pkg`: state encoding (IDLE/ISSUE/WAIT/RESP) and `ex_op` encodings (MUL_W, MULH_W, MULH_WU).
- One sub-module, `mul_reuse_buf`, holds the reuse entry, compare logic and hit flag. It is instantiated only under `MUL_ISSUE_REUSE_EN`.

## Test plan
- MUL.W, src1=0xFFFFFFFF, src2=0x00000002 → `mul_signed`=1, `mul_start` in cycle 1, `res_data`=0xFFFFFFFE with `res_valid` in cycle 3, `ex_stall` high in cycles 0–2.
- MULH.W with the same operands → `res_data`=0xFFFFFFFF. MULH.WU with the same operands → `mul_signed`=0, `res_data`=0x00000001.
- `flush` asserted during WAIT, `mul_done` in the same cycle → next state IDLE, no `res_valid`. A following MUL.W 3×5 → `res_data`=0x0000000F.
- `rst` driven low during ISSUE → `mul_start` drops immediately, state IDLE. After release, a MUL.W 7×6 → `res_data`=0x0000002A.
- With `MUL_ISSUE_REUSE_EN`: MUL.W 0x10000×0x10000, then MULH.W with the same operands → second result `res_data`=0x00000001 in cycle 1, with no second `mul_start`.
- With `MUL_ISSUE_REUSE_EN`, signedness mismatch: MULH.WU after MULH.W with the same operands → miss, full 3-cycle path taken.
